// File: rtl/i2c_arb_pkg.sv
// Shared types and width helpers for the I2C bus arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Bits needed to hold any value in 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int owner_width(input int num_masters);
    return idx_width(num_masters);
  endfunction

  // A counter that runs from max_count-1 down to 0 (or 0 up to max_count-1).
  function automatic int count_width(input int max_count);
    return idx_width(max_count);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after the last owner, wrapping.
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]              eligible,
  input  logic [owner_width(NUM_MASTERS)-1:0] last,
  output logic [NUM_MASTERS-1:0]              winner_oh,
  output logic [owner_width(NUM_MASTERS)-1:0] winner_idx,
  output logic                                valid
);

  localparam int OW = owner_width(NUM_MASTERS);

  always_comb begin
    int cand;
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    // The last owner is scanned last, so it only wins when nobody else asks.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(last) + k) % NUM_MASTERS;
      if (!valid && eligible[cand]) begin
        valid           = 1'b1;
        winner_idx      = OW'(cand);
        winner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of a shared open-drain I2C bus with bus-free gap and grant watchdog.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_MASTERS-1:0]              req,
  input  logic [NUM_MASTERS-1:0]              scl_low_in,
  input  logic [NUM_MASTERS-1:0]              sda_low_in,
  output logic [NUM_MASTERS-1:0]              grant,
  output logic [owner_width(NUM_MASTERS)-1:0] owner,
  output logic                                busy,
  output logic                                timeout_err,
  output logic                                scl_low,
  output logic                                sda_low
);

  localparam int OW = owner_width(NUM_MASTERS);
  localparam int GW = count_width(GAP_CYCLES);
  localparam int TW = count_width(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e             state, state_d;
  logic [NUM_MASTERS-1:0] grant_d, blocked, blocked_d;
  logic [OW-1:0]          owner_d;
  logic [GW-1:0]          gap_cnt, gap_d;
  logic [TW-1:0]          wd_cnt, wd_d;
  logic                   timeout_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [OW-1:0]          pick_idx;
  logic                   pick_vld;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .eligible   (req & ~blocked),
    .last       (owner),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= OW'(NUM_MASTERS - 1);
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      blocked     <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      owner       <= owner_d;
      gap_cnt     <= gap_d;
      wd_cnt      <= wd_d;
      timeout_err <= timeout_d;
      blocked     <= blocked_d;
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    owner_d   = owner;
    gap_d     = gap_cnt;
    wd_d      = wd_cnt;
    timeout_d = 1'b0;
    // A timed-out master stays locked out until it lets go of req.
    blocked_d = blocked & req;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = pick_oh;
          owner_d = pick_idx;
          wd_d    = '0;
        end
      end
      GRANT: begin
        // A release on the expiry cycle wins over the watchdog.
        if (!req[owner]) begin
          state_d = GAP;
          grant_d = '0;
          gap_d   = GAP_LOAD;
        end else if (wd_cnt == WD_LAST) begin
          state_d          = GAP;
          grant_d          = '0;
          gap_d            = GAP_LOAD;
          timeout_d        = 1'b1;
          blocked_d[owner] = 1'b1;
        end else begin
          wd_d = wd_cnt + TW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_d   = gap_cnt - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign scl_low = |(grant & scl_low_in);
  assign sda_low = |(grant & sda_low_in);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomised scoreboard bench for i2c_bus_arbiter against a cycle-count reference model.
module tb_i2c_bus_arbiter;

  localparam int NM  = 4;
  localparam int GAP = 8;
  localparam int TO  = 40;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NM-1:0] req = '0;
  logic [NM-1:0] scl_in = '0;
  logic [NM-1:0] sda_in = '0;
  logic [NM-1:0] pad_force = '0;
  logic [NM-1:0] grant;
  logic [1:0]    owner;
  logic          busy, timeout_err, scl_low, sda_low;

  int checks = 0;
  int failures = 0;

  i2c_bus_arbiter #(.NUM_MASTERS(NM), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .scl_low_in  (scl_in),
    .sda_low_in  (sda_in),
    .grant       (grant),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .scl_low     (scl_low),
    .sda_low     (sda_low)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, want, $time);
    end
  endtask

  // Reference model: tracks ownership by absolute edge numbers.
  typedef struct {
    logic [NM-1:0] grant;
    int            owner;
    bit            busy;
    bit            terr;
  } exp_t;
  exp_t exp_q[$];

  int      e_num = 0;
  bit      m_granted = 0;
  int      m_owner = NM - 1;
  int      m_start = 0;
  int      m_rel = -1000;
  bit [NM-1:0] m_blk = '0;

  always @(posedge clock) begin
    exp_t x;
    bit [NM-1:0] r, elig, nb;
    bit terr, found;
    int c;
    terr = 0;
    e_num++;
    if (!reset_n) begin
      m_granted = 0; m_owner = NM - 1; m_blk = '0; m_rel = -1000;
    end else begin
      r = req;
      elig = r & ~m_blk;
      nb = m_blk & r;
      if (m_granted) begin
        if (!r[m_owner]) begin
          m_granted = 0; m_rel = e_num;
        end else if (e_num - m_start == TO) begin
          m_granted = 0; m_rel = e_num; terr = 1; nb[m_owner] = 1'b1;
        end
      end else if (e_num > m_rel + GAP && elig != '0) begin
        found = 0;
        for (int k = 1; k <= NM; k++) begin
          c = (m_owner + k) % NM;
          if (!found && elig[c]) begin m_owner = c; found = 1; end
        end
        m_granted = 1; m_start = e_num;
      end
      m_blk = nb;
    end
    x.grant = m_granted ? NM'(1 << m_owner) : '0;
    x.owner = m_owner;
    x.busy  = m_granted || (e_num < m_rel + GAP);
    x.terr  = terr;
    exp_q.push_back(x);
  end

  // Monitor: one expected entry per clock, compared mid-cycle.
  always @(negedge clock) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (!reset_n) begin
        x.grant = '0; x.owner = NM - 1; x.busy = 0; x.terr = 0;
      end
      chk("grant", int'(grant), int'(x.grant));
      chk("owner", int'(owner), x.owner);
      chk("busy", int'(busy), int'(x.busy));
      chk("timeout_err", int'(timeout_err), int'(x.terr));
      chk("scl_low", int'(scl_low), (x.grant != '0) ? int'(scl_in[x.owner]) : 0);
      chk("sda_low", int'(sda_low), (x.grant != '0) ? int'(sda_in[x.owner]) : 0);
    end
  end

  // Pad enables of every master toggle freely; pad_force pins selected bits high.
  always @(posedge clock) begin
    #1;
    scl_in = NM'($urandom) | pad_force;
    sda_in = NM'($urandom);
  end

  task automatic wait_any(output int idx);
    int n;
    idx = -1;
    n = 0;
    while (idx < 0 && n < 300) begin
      @(posedge clock); #1; n++;
      for (int i = 0; i < NM; i++) if (grant[i]) idx = i;
    end
    if (idx < 0) begin
      checks++; failures++;
      $display("FAIL grant_wait: no grant within %0d cycles", n);
    end
  endtask

  task automatic wait_grant(input int m);
    int n;
    n = 0;
    while (!grant[m] && n < 300) begin @(posedge clock); #1; n++; end
    chk("grant_wait_m", int'(grant[m]), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin @(posedge clock); #1; n++; end
    chk("idle_wait", int'(busy), 0);
  endtask

  initial begin
    int cnt, terr_seen, regrants, idx;
    int order[5] = '{0, 1, 2, 3, 0};
    int dropdiv[NM] = '{12, 12, 20, 60};

    // Reset, two requesters, release of master 0 and gap length.
    repeat (3) @(posedge clock);
    #1; reset_n = 1'b1; req = 4'b0011;
    @(posedge clock); #1;
    chk("first_grant", int'(grant), 1);
    chk("first_owner", int'(owner), 0);
    repeat (5) @(posedge clock);
    #1; req[0] = 1'b0;
    @(posedge clock); #1;
    chk("release_grant", int'(grant), 0);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(posedge clock); #1; end
    chk("gap_busy_len", cnt, GAP);
    @(posedge clock); #1;
    chk("second_grant", int'(grant), 2);
    repeat (4) @(posedge clock);
    #1; req = '0;
    wait_idle();

    // Watchdog on master 1, then lockout until req toggles.
    req = 4'b0010;
    wait_grant(1);
    cnt = 1; terr_seen = 0; regrants = 0;
    while (grant[1] && cnt < TO + 20) begin
      @(posedge clock); #1;
      if (grant[1]) cnt++;
      if (timeout_err) terr_seen++;
    end
    chk("grant_len", cnt, TO);
    repeat (2 * GAP + 10) begin
      @(posedge clock); #1;
      if (grant != '0) regrants++;
      if (timeout_err) terr_seen++;
    end
    chk("timeout_pulses", terr_seen, 1);
    chk("blocked_no_regrant", regrants, 0);
    req[1] = 1'b0;
    @(posedge clock); #1; req[1] = 1'b1;
    wait_grant(1);
    req = '0;
    wait_idle();

    // Reset, then all four requesting: round-robin order.
    reset_n = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_any(idx);
      chk("rr_order", idx, order[i]);
      if (idx >= 0) begin
        repeat (9) @(posedge clock);
        #1; req[idx] = 1'b0;
        @(posedge clock); #1; req[idx] = 1'b1;
      end
    end
    req = '0;
    wait_idle();

    // Asynchronous reset during a grant releases the pads at once.
    req = 4'b0100;
    wait_grant(2);
    pad_force = 4'b0100;
    @(posedge clock); #2;
    chk("scl_driven", int'(scl_low), 1);
    #1; reset_n = 1'b0;
    #1;
    chk("async_scl", int'(scl_low), 0);
    chk("async_grant", int'(grant), 0);
    chk("async_owner", int'(owner), NM - 1);
    @(posedge clock); #1;
    reset_n = 1'b1; pad_force = '0; req = 4'b1111;
    wait_any(idx);
    chk("post_reset_winner", idx, 0);
    req = '0;
    wait_idle();

    // Release on the very edge the watchdog expires.
    req = 4'b0100;
    wait_grant(2);
    repeat (TO - 1) @(posedge clock);
    #1; req[2] = 1'b0;
    @(posedge clock); #1;
    chk("tie_timeout_err", int'(timeout_err), 0);
    chk("tie_grant", int'(grant), 0);
    req[2] = 1'b1;
    wait_grant(2);
    repeat (3) @(posedge clock);
    #1; req = '0;
    wait_idle();

    // Random traffic; master 3 tends to overstay and trip the watchdog.
    repeat (1500) begin
      @(posedge clock); #1;
      for (int i = 0; i < NM; i++) begin
        if (req[i]) begin
          if ($urandom_range(dropdiv[i] - 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    wait_idle();
    repeat (3) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running at t=%0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule
